// File: rtl/pi_inv_lane_stream.sv
// pi_inv_lane_stream
// Lane-serial inverse of the Keccak pi step. A full 5x5 state arrives as
// 25 lanes (lane k is (x,y) = (k%5, k/5)), is buffered, then leaves as 25
// lanes in the inverse-pi arrangement C[x][y] = B[y][(2x+3y)%5].
// Fill and drain never overlap.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_valid   input lane presented
//   in_data    input lane, LANE_SIZE bits
//   in_ready   block accepts a lane (high only while filling)
//   out_valid  output lane presented (high only while draining)
//   out_ready  consumer accepts the output lane
//   out_data   output lane, LANE_SIZE bits
//   out_last   marks the 25th output lane of a frame
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | accepting input lanes into the buffer, in_cnt tracks lane k
// DRAIN | presenting permuted lanes, out_cnt tracks lane j, buffer frozen

module pi_inv_lane_stream #(
    parameter int LANE_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [LANE_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANE_SIZE-1:0] out_data,
    output logic                 out_last
);

    localparam int         ROW_SIZE  = 5;
    localparam int         COL_SIZE  = 5;
    localparam int         NUM_LANES = ROW_SIZE * COL_SIZE;
    localparam logic [4:0] LAST_LANE = 5'(NUM_LANES - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           in_cnt_q, in_cnt_d;
    logic [4:0]           out_cnt_q, out_cnt_d;
    logic                 wr_en;
    logic [4:0]           rd_idx;
    logic [LANE_SIZE-1:0] lane_buf [NUM_LANES];

    // Buffer is stored flat, lane (x,y) at x + 5y, so the write address is
    // simply in_cnt. The read address for output lane j = x + 5y is the
    // flat position of B[y][(2x+3y)%5], i.e. y + 5*((2x+3y)%5), precomputed
    // so no modulo hardware is needed. Unreachable counts fall back to 0.
    function automatic logic [4:0] src_lane(input logic [4:0] j);
        logic [4:0] idx;
        case (j)
            5'd0:  idx = 5'd0;
            5'd1:  idx = 5'd10;
            5'd2:  idx = 5'd20;
            5'd3:  idx = 5'd5;
            5'd4:  idx = 5'd15;
            5'd5:  idx = 5'd16;
            5'd6:  idx = 5'd1;
            5'd7:  idx = 5'd11;
            5'd8:  idx = 5'd21;
            5'd9:  idx = 5'd6;
            5'd10: idx = 5'd7;
            5'd11: idx = 5'd17;
            5'd12: idx = 5'd2;
            5'd13: idx = 5'd12;
            5'd14: idx = 5'd22;
            5'd15: idx = 5'd23;
            5'd16: idx = 5'd8;
            5'd17: idx = 5'd18;
            5'd18: idx = 5'd3;
            5'd19: idx = 5'd13;
            5'd20: idx = 5'd14;
            5'd21: idx = 5'd24;
            5'd22: idx = 5'd9;
            5'd23: idx = 5'd19;
            5'd24: idx = 5'd4;
            default: idx = 5'd0;
        endcase
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_buf[i] <= '0;
            end
        end else if (wr_en) begin
            lane_buf[in_cnt_q] <= in_data;
        end
    end

    // Handshake outputs depend only on registered state, never on
    // in_valid or out_ready.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        wr_en     = 1'b0;
        rd_idx    = src_lane(out_cnt_q);

        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (in_cnt_q == LAST_LANE) begin
                        in_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        in_cnt_d = in_cnt_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = lane_buf[rd_idx];
                out_last  = (out_cnt_q == LAST_LANE);
                if (out_ready) begin
                    if (out_cnt_q == LAST_LANE) begin
                        out_cnt_d = '0;
                        state_d   = FILL;
                    end else begin
                        out_cnt_d = out_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_pi_inv_lane_stream.sv
module tb_pi_inv_lane_stream;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         out_last;
    logic [W-1:0] out_data;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [W-1:0] frame_in  [25];
    logic [W-1:0] frame_exp [25];
    logic [W-1:0] orig      [25];

    always #5 clk = ~clk;

    pi_inv_lane_stream #(.LANE_SIZE(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: output lane (x,y) is input lane B[y][(2x+3y)%5], where
    // input lane (a,b) sits at stream position a + 5b.
    task automatic inv_pi_model();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                frame_exp[x + 5*y] = frame_in[y + 5*((2*x + 3*y) % 5)];
    endtask

    task automatic load_index_frame();
        for (int k = 0; k < 25; k++) frame_in[k] = W'(k);
        inv_pi_model();
    endtask

    // Runs one frame starting at posedge+1. gap: drop in_valid every third
    // fill cycle. stall: random out_ready. abort_at >= 0: pull reset once
    // that many output lanes have been handshaken.
    task automatic do_frame(input bit gap, input bit stall, input int abort_at);
        int  k = 0;
        int  j = 0;
        int  cyc = 0;
        bit  hs;
        while (k < 25 && cyc < 400) begin
            in_valid  = gap ? (cyc % 3 != 2) : 1'b1;
            in_data   = in_valid ? frame_in[k] : {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            chk_bit("fill_in_ready", in_ready, 1'b1);
            chk_bit("fill_out_valid", out_valid, 1'b0);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            cyc++;
        end
        if (k < 25) begin
            chk_word("fill_timeout_lanes", W'(k), W'(25));
            return;
        end
        chk_bit("latency_out_valid", out_valid, 1'b1);
        cyc = 0;
        while (j < 25 && cyc < 400) begin
            if (abort_at >= 0 && j == abort_at) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                chk_bit("rst_out_valid_async", out_valid, 1'b0);
                @(posedge clk); #1;
                chk_bit("rst_out_valid", out_valid, 1'b0);
                chk_bit("rst_in_ready", in_ready, 1'b1);
                chk_bit("rst_out_last", out_last, 1'b0);
                chk_word("rst_out_data", out_data, '0);
                rst_n = 1'b1;
                return;
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom};
            chk_bit("drain_out_valid", out_valid, 1'b1);
            chk_bit("drain_in_ready", in_ready, 1'b0);
            chk_word($sformatf("out_data_j%0d", j), out_data, frame_exp[j]);
            chk_bit($sformatf("out_last_j%0d", j), out_last, (j == 24));
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            if (hs) j++;
            cyc++;
        end
        if (j < 25) begin
            chk_word("drain_timeout_lanes", W'(j), W'(25));
        end else begin
            chk_bit("return_in_ready", in_ready, 1'b1);
            chk_bit("return_out_valid", out_valid, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_in_ready", in_ready, 1'b1);
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_out_last", out_last, 1'b0);
        chk_word("reset_out_data", out_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_bit("post_reset_in_ready", in_ready, 1'b1);

        // index pattern, full rate
        load_index_frame();
        do_frame(1'b0, 1'b0, -1);
        // input gaps every third cycle
        do_frame(1'b1, 1'b0, -1);
        // random backpressure
        do_frame(1'b0, 1'b1, -1);
        // reset in the middle of the drain, after lane j = 7
        do_frame(1'b0, 1'b0, 8);
        // fresh frame after reset, then a back-to-back pair
        do_frame(1'b0, 1'b0, -1);
        do_frame(1'b0, 1'b0, -1);
        do_frame(1'b0, 1'b0, -1);

        // round trip: random state through forward pi, then this block
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 25; i++) orig[i] = {$urandom, $urandom};
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    frame_in[y + 5*((2*x + 3*y) % 5)] = orig[x + 5*y];
            for (int i = 0; i < 25; i++) frame_exp[i] = orig[i];
            do_frame(f % 3 == 1, f % 2 == 1, -1);
        end

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
